// File: rtl/keypad_scan_controller.sv
// Column-scanning controller for a 3x4 membrane keypad: drives one column at a
// time, assembles full-keypad frames, debounces them and emits one event per press.
module keypad_scan_controller #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic [3:0] rows,
  output logic [2:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STB_W = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE);

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_e;

  // CL_EMPTY marks "no previous frame", so the first frame never counts as a repeat
  typedef enum logic [1:0] {
    CL_EMPTY,
    CL_NONE,
    CL_KEY,
    CL_MULTI
  } class_e;

  state_e           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       slot_q, slot_d;
  logic [11:0]      frame_q, frame_d;
  logic             frame_rdy_q, frame_rdy_d;
  class_e           prev_class_q, prev_class_d;
  logic [3:0]       prev_key_q, prev_key_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_held_q, key_held_d;

  logic [3:0]       bit_cnt;
  logic [3:0]       key_idx;
  class_e           frame_class;
  logic             same_as_prev;
  logic [STB_W-1:0] stable_next;
  logic             stable_done;

  // Frame bit index is col*4 + row; map it to the printed legend of the key
  function automatic logic [3:0] code_of(input logic [3:0] idx);
    logic [3:0] r;
    logic [3:0] c;
    logic [3:0] code;
    r = {2'b00, idx[1:0]};
    c = {2'b00, idx[3:2]};
    if (r == 4'd3) begin
      case (c)
        4'd0:    code = 4'hA;
        4'd1:    code = 4'h0;
        default: code = 4'hB;
      endcase
    end else begin
      code = r * 4'd3 + c + 4'd1;
    end
    return code;
  endfunction

  always_comb begin
    bit_cnt = '0;
    key_idx = '0;
    for (int i = 0; i < 12; i++) begin
      if (frame_q[i]) begin
        bit_cnt = bit_cnt + 4'd1;
        key_idx = 4'(i);
      end
    end
    if (bit_cnt == 4'd0) begin
      frame_class = CL_NONE;
    end else if (bit_cnt == 4'd1) begin
      frame_class = CL_KEY;
    end else begin
      frame_class = CL_MULTI;
    end
  end

  always_comb begin
    same_as_prev = (frame_class == prev_class_q) &&
                   ((frame_class != CL_KEY) || (key_idx == prev_key_q));
    if (same_as_prev) begin
      stable_next = (stable_q == STB_MAX) ? stable_q : stable_q + STB_W'(1);
    end else begin
      stable_next = STB_W'(1);
    end
    stable_done = (stable_next == STB_MAX);
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    frame_d      = frame_q;
    frame_rdy_d  = 1'b0;
    prev_class_d = prev_class_q;
    prev_key_d   = prev_key_q;
    stable_d     = stable_q;
    key_valid_d  = 1'b0;
    key_code_d   = key_code_q;
    key_held_d   = key_held_q;

    case (state_q)
      ST_IDLE: begin
        if (scan_en) begin
          state_d = ST_SCAN;
          col_d   = 2'd0;
          cnt_d   = '0;
        end
      end

      default: begin
        if (!scan_en) begin
          // Dropping enable abandons the partial frame and forgets the held key
          state_d      = ST_IDLE;
          col_d        = 2'd0;
          cnt_d        = '0;
          prev_class_d = CL_EMPTY;
          prev_key_d   = '0;
          stable_d     = '0;
          key_held_d   = 1'b0;
        end else begin
          if (frame_rdy_q) begin
            prev_class_d = frame_class;
            prev_key_d   = key_idx;
            stable_d     = stable_next;
            if (stable_done) begin
              if ((frame_class == CL_KEY) && !key_held_q) begin
                key_valid_d = 1'b1;
                key_code_d  = code_of(key_idx);
                key_held_d  = 1'b1;
              end else if (frame_class == CL_NONE) begin
                key_held_d = 1'b0;
              end
            end
          end

          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            case (col_q)
              2'd0: begin
                slot_d[3:0] = rows;
                col_d       = 2'd1;
              end
              2'd1: begin
                slot_d[7:4] = rows;
                col_d       = 2'd2;
              end
              default: begin
                frame_d     = {rows, slot_q};
                frame_rdy_d = 1'b1;
                col_d       = 2'd0;
              end
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_q        <= 2'd0;
      cnt_q        <= '0;
      slot_q       <= '0;
      frame_q      <= '0;
      frame_rdy_q  <= 1'b0;
      prev_class_q <= CL_EMPTY;
      prev_key_q   <= '0;
      stable_q     <= '0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      key_held_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      frame_q      <= frame_d;
      frame_rdy_q  <= frame_rdy_d;
      prev_class_q <= prev_class_d;
      prev_key_q   <= prev_key_d;
      stable_q     <= stable_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_held_q   <= key_held_d;
    end
  end

  always_comb begin
    cols = 3'b000;
    if (state_q == ST_SCAN) begin
      case (col_q)
        2'd0:    cols = 3'b001;
        2'd1:    cols = 3'b010;
        default: cols = 3'b100;
      endcase
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller: a keypad model drives the rows, a frame-history
// reference model predicts every output cycle, plus directed literal checks.
module tb_keypad_scan_controller;

  localparam int SD = 4;
  localparam int DB = 4;
  localparam int FR = 3 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scan_en = 1'b0;
  logic [3:0] rows = 4'b0000;
  logic [2:0] cols;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  always #5 clk = ~clk;

  keypad_scan_controller #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_en  (scan_en),
    .rows     (rows),
    .cols     (cols),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse = -1;
  int entry_cyc = 0;
  logic [11:0] pressed = 12'h000;  // bit r*3+c set = key at row r, column c is down

  // Reference model state: scan time since enable, sampled columns, frame history
  int keymap [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
  bit         m_scan = 1'b0;
  int         m_t = 0;
  logic [3:0] m_fr [3];
  bit         m_pend = 1'b0;
  int         m_pend_lbl = -1;
  int         m_hist [$];
  bit         m_valid = 1'b0;
  logic [3:0] m_code = 4'h0;
  bit         m_held = 1'b0;
  logic [2:0] m_cols = 3'b000;

  function automatic logic [3:0] col_rows(input logic [2:0] cdrv, input logic [11:0] p);
    logic [3:0] v;
    v = 4'b0000;
    for (int c = 0; c < 3; c++)
      if (cdrv[c])
        for (int r = 0; r < 4; r++)
          if (p[r*3+c]) v[r] = 1'b1;
    return v;
  endfunction

  // -1 = nothing pressed, 0..11 = single key r*3+c, 100 = several keys
  function automatic int label_of(input logic [3:0] f0, input logic [3:0] f1,
                                  input logic [3:0] f2);
    int n;
    int lbl;
    logic [3:0] f [3];
    f[0] = f0; f[1] = f1; f[2] = f2;
    n = 0;
    lbl = -1;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++)
        if (f[c][r]) begin
          n++;
          lbl = r * 3 + c;
        end
    if (n == 0) return -1;
    if (n == 1) return lbl;
    return 100;
  endfunction

  task automatic model_reset();
    m_scan  = 1'b0;
    m_t     = 0;
    m_pend  = 1'b0;
    m_hist.delete();
    m_valid = 1'b0;
    m_code  = 4'h0;
    m_held  = 1'b0;
    m_cols  = 3'b000;
  endtask

  task automatic model_edge();
    int run;
    int c;
    if (!rst_n) begin
      model_reset();
    end else if (!m_scan) begin
      m_valid = 1'b0;
      if (scan_en) begin
        m_scan = 1'b1;
        m_t    = 0;
        m_pend = 1'b0;
        m_hist.delete();
      end
    end else if (!scan_en) begin
      m_scan  = 1'b0;
      m_valid = 1'b0;
      m_held  = 1'b0;
      m_pend  = 1'b0;
      m_hist.delete();
      m_t     = 0;
    end else begin
      m_valid = 1'b0;
      if (m_pend) begin
        m_hist.push_back(m_pend_lbl);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        run = 0;
        for (int i = m_hist.size() - 1; i >= 0 && m_hist[i] == m_pend_lbl; i--) run++;
        if (run >= DB) begin
          if (m_pend_lbl >= 0 && m_pend_lbl < 100 && !m_held) begin
            m_valid = 1'b1;
            m_code  = 4'(keymap[m_pend_lbl]);
            m_held  = 1'b1;
          end else if (m_pend_lbl == -1) begin
            m_held = 1'b0;
          end
        end
        m_pend = 1'b0;
      end
      if (m_t % SD == SD - 1) begin
        c = (m_t / SD) % 3;
        m_fr[c] = rows;
        if (c == 2) begin
          m_pend     = 1'b1;
          m_pend_lbl = label_of(m_fr[0], m_fr[1], m_fr[2]);
        end
      end
      m_t++;
    end
    m_cols = m_scan ? (3'b001 << ((m_t / SD) % 3)) : 3'b000;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: advance the model on the rising edge, compare and refresh rows on the falling edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      checks++;
      if ({cols, key_valid, key_code, key_held} !== {m_cols, m_valid, m_code, m_held}) begin
        failures++;
        $display("FAIL model cyc=%0d got cols=%b v=%b code=%h held=%b expected cols=%b v=%b code=%h held=%b",
                 cyc, cols, key_valid, key_code, key_held, m_cols, m_valid, m_code, m_held);
      end
      if (key_valid === 1'b1) begin
        pulses++;
        last_pulse = cyc;
      end
      rows = col_rows(cols, pressed);
    end
  endtask

  task automatic set_keys(input logic [11:0] p);
    pressed = p;
    rows = col_rows(cols, pressed);
  endtask

  task automatic wait_pulse(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (pulses > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int r;
    int b0;
    int b1;
    logic [11:0] p;

    // Reset and first scan, then an asynchronous reset in the middle of column 1
    scan_en = 1'b1;
    step(3);
    check("reset_cols", 32'(cols), 32'h0);
    check("reset_code", 32'(key_code), 32'h0);
    rst_n = 1'b1;
    step(6);
    check("mid_col1_cols", 32'(cols), 32'h2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_cols", 32'(cols), 32'h0);
    check("async_rst_outs", 32'({key_valid, key_held, key_code}), 32'h0);
    step(2);
    rst_n = 1'b1;
    set_keys(12'h010);  // '5'

    // Column sequence after reset release, with '5' held from the start
    for (int k = 0; k < 14; k++) begin
      step(1);
      if (k == 0) entry_cyc = cyc;
      check("cols_seq", 32'(cols), 32'(3'b001 << ((k / SD) % 3)));
    end

    // Clean press of '5'
    wait_pulse(0, 200, ok);
    check("press5_seen", 32'(ok), 32'h1);
    check("press5_latency", 32'(last_pulse - entry_cyc), 32'd49);
    check("press5_code", 32'(key_code), 32'h5);
    check("press5_held", 32'(key_held), 32'h1);
    step(20 * FR);
    check("press5_single", 32'(pulses), 32'd1);

    // Release, then '#'
    set_keys(12'h000);
    step(6 * FR);
    check("release5_held", 32'(key_held), 32'h0);
    set_keys(12'h800);
    step(7 * FR);
    check("hash_pulses", 32'(pulses), 32'd2);
    check("hash_code", 32'(key_code), 32'hB);

    // Bounce on '7', one frame on and one off
    set_keys(12'h000);
    step(6 * FR);
    for (int i = 0; i < 20; i++) begin
      set_keys((i % 2 == 1) ? 12'h040 : 12'h000);
      step(FR);
    end
    check("bounce_pulses", 32'(pulses), 32'd2);
    check("bounce_held", 32'(key_held), 32'h0);

    // '1' and '2' together, then '2' released
    set_keys(12'h000);
    step(6 * FR);
    set_keys(12'h003);
    step(10 * FR);
    check("multi_pulses", 32'(pulses), 32'd2);
    set_keys(12'h001);
    step(7 * FR);
    check("single1_pulses", 32'(pulses), 32'd3);
    check("single1_code", 32'(key_code), 32'h1);

    // scan_en drop with '9' held, then re-enable
    set_keys(12'h000);
    step(6 * FR);
    set_keys(12'h100);
    step(7 * FR);
    check("nine_code", 32'(key_code), 32'h9);
    check("nine_held", 32'(key_held), 32'h1);
    scan_en = 1'b0;
    step(1);
    check("drop_cols", 32'(cols), 32'h0);
    check("drop_held", 32'(key_held), 32'h0);
    check("drop_code", 32'(key_code), 32'h9);
    step(5);
    check("drop_pulses", 32'(pulses), 32'd4);
    scan_en = 1'b1;
    step(7 * FR);
    check("reenable_pulses", 32'(pulses), 32'd5);

    // Randomised keypad activity with occasional enable drops
    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 30) begin
        p = 12'h000;
      end else if (r < 80) begin
        p = 12'h001 << $urandom_range(0, 11);
      end else begin
        b0 = int'($urandom_range(0, 11));
        b1 = (b0 + int'($urandom_range(1, 11))) % 12;
        p = (12'h001 << b0) | (12'h001 << b1);
      end
      set_keys(p);
      if ($urandom_range(0, 19) == 0) begin
        scan_en = 1'b0;
        step(int'($urandom_range(1, 5)));
        scan_en = 1'b1;
      end
      step(int'($urandom_range(1, 90)));
    end

    // Asynchronous reset while a key is held
    set_keys(12'h000);
    step(6 * FR);
    set_keys(12'h004);  // '3'
    step(7 * FR);
    check("three_code", 32'(key_code), 32'h3);
    check("three_held", 32'(key_held), 32'h1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_held_outs", 32'({cols, key_valid, key_held, key_code}), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan_controller.md
# keypad_scan_controller

Scans the 3-column × 4-row membrane keypad of the safe, debounces it, and emits one single-cycle key event per physical press. It sequences the keypad drive lines and turns raw row levels into validated 4-bit key codes for the code-entry logic. Single clock domain with asynchronous active-low reset. It sits between the keypad pins and the safe control logic.

## Interface

Parameters:
- SCAN_DIV, default 1000: clock cycles each column is driven. Must be ≥ 2.
- DEBOUNCE, default 4: consecutive identical full-keypad frames required to accept a press or a release. Must be ≥ 1.

Ports:
- clk, input, 1: clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- scan_en, input, 1: high enables scanning; low idles the block.
- rows, input, 4: row sense lines, active-high. Row r reads high when a key in row r of the driven column is pressed. Already synchronised upstream.
- cols, output, 3: column drive, one-hot and active-high; 3'b000 when idle.
- key_valid, output, 1: one-cycle pulse marking a newly accepted key.
- key_code, output, 4: code of the last accepted key. Valid at the key_valid cycle and held until the next accepted key.
- key_held, output, 1: high from acceptance until a debounced release.

## Operation

- Keymap, row r / column c:
  - row 0: 1, 2, 3
  - row 1: 4, 5, 6
  - row 2: 7, 8, 9
  - row 3: * = 4'hA, 0 = 4'h0, # = 4'hB
- States:
  - IDLE: cols = 0. Moves to SCAN on the first edge where scan_en = 1.
  - SCAN: drives column c (0→1→2→0…) for SCAN_DIV cycles. The dwell counter is $clog2(SCAN_DIV) bits wide and wraps from SCAN_DIV−1 to 0.
- Sampling:
  - On the last dwell cycle (count = SCAN_DIV−1), rows are captured into a 12-bit frame slot for column c.
  - Sampling column 2 completes the frame.
- Frame classification:
  - NONE: zero bits set.
  - KEY(k): exactly one bit set.
  - MULTI: two or more bits set.
- Debounce, one update per completed frame:
  - If the class or key equals the previous frame's, stable_cnt increments, saturating at DEBOUNCE.
  - Otherwise stable_cnt = 1 and the previous class is replaced.
- Accept a key when stable_cnt reaches DEBOUNCE on class KEY(k) and key_held = 0:
  - key_valid pulses.
  - key_code = k.
  - key_held = 1.
- Release when stable_cnt reaches DEBOUNCE on class NONE: key_held = 0 and the block re-arms.
- MULTI never produces an event and never releases. A held key stays held through ghosting.
- A different single key stable while key_held = 1 produces no event. A NONE release is required first.
- scan_en falling during SCAN:
  - Next edge: state goes to IDLE and cols = 0.
  - The partial frame is discarded.
  - Debounce history is cleared and key_held = 0, with no pulse.
  - key_code is retained.
- scan_en rising restarts at column 0 with dwell count 0 and an empty history.

## Timing

- Reset (asynchronous, immediate): cols = 0, key_valid = 0, key_code = 0, key_held = 0, state = IDLE, counters and history cleared.
- Release of rst_n with scan_en = 1: cols = 3'b001 after the first rising edge.
- Column period is SCAN_DIV cycles; frame period is 3·SCAN_DIV cycles.
- There are no gap cycles between columns or frames. Classification and debounce evaluation overlap the next column-0 dwell.
- key_valid and the key_code update occur in the cycle after the column-2 sample of the DEBOUNCE-th stable frame. key_held rises in that same cycle.
- Press latency from the first sampling edge with the key down: (DEBOUNCE−1)·3·SCAN_DIV + (column-2 offset) + 1 cycles. Release latency follows the same rule.
- key_valid is never high for two consecutive cycles.

## Test plan

- Async reset: SCAN_DIV = 4, pulse rst_n low mid-dwell of column 1 → all outputs 0 with no clock edge. After release, cols = 001 for 4 cycles, then 010, then 100, repeating.
- Clean press: DEBOUNCE = 4, hold row 1 high whenever cols = 010 (key '5') → exactly one key_valid with key_code = 4'h5, one cycle after the 4th frame's column-2 sample. key_held = 1, and no further pulses for 20 frames.
- Release and repress: release '5' for 4 frames, then press '#' (row 3, col 2) → key_held falls after 4 NONE frames, then one pulse with key_code = 4'hB.
- Bounce: toggle key '7' on alternate frames for 20 frames → no key_valid and key_held stays 0.
- Multi-key: press '1' and '2' together for 10 frames → no pulse. Then release '2' only → pulse with key_code = 4'h1 after 4 frames.
- scan_en drop: with '9' held and key_held = 1, deassert scan_en → next cycle cols = 0, key_held = 0, no pulse, key_code stays 4'h9. Re-enable with '9' still pressed → new pulse after 4 frames.
